// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-stage definitions: skid register FSM state encoding and helpers.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    PSR_EMPTY = 2'b00,
    PSR_ONE   = 2'b01,
    PSR_TWO   = 2'b10
  } psr_state_e;

  // 2'b11 is unreachable; it reports as empty, like the state it recovers to.
  function automatic logic [1:0] psr_occ(input psr_state_e st);
    unique case (st)
      PSR_ONE: return 2'd1;
      PSR_TWO: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages through a skid register.
interface pipe_skid_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_data_reg.sv
// WIDTH-bit data register with synchronous reset/clear to RST_VAL and load enable.
module pipe_data_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with one-entry skid buffer and synchronous flush.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  pipe_skid_reg_if.slave  bus
);

  psr_state_e       state_q, state_d;
  logic             in_fire, out_fire;
  logic             m_en, s_en, m_from_s;
  logic [WIDTH-1:0] m_d, m_q, s_q;

  // All outputs decode the state flop only, so no input reaches them combinationally.
  assign bus.in_ready  = (state_q != PSR_TWO);
  assign bus.out_valid = (state_q != PSR_EMPTY);
  assign bus.out_data  = m_q;
  assign bus.occupancy = psr_occ(state_q);

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d  = state_q;
    m_en     = 1'b0;
    s_en     = 1'b0;
    m_from_s = 1'b0;
    if (flush) begin
      state_d = PSR_EMPTY;
    end else begin
      unique case (state_q)
        PSR_EMPTY: begin
          if (in_fire) begin
            m_en    = 1'b1;
            state_d = PSR_ONE;
          end
        end
        PSR_ONE: begin
          if (in_fire && out_fire) begin
            m_en = 1'b1;
          end else if (in_fire) begin
            s_en    = 1'b1;
            state_d = PSR_TWO;
          end else if (out_fire) begin
            state_d = PSR_EMPTY;
          end
        end
        PSR_TWO: begin
          if (out_fire) begin
            m_en     = 1'b1;
            m_from_s = 1'b1;
            state_d  = PSR_ONE;
          end
        end
        default: state_d = PSR_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PSR_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign m_d = m_from_s ? s_q : bus.in_data;

  pipe_data_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (m_en),
    .d   (m_d),
    .q   (m_q)
  );

  pipe_data_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (s_en),
    .d   (bus.in_data),
    .q   (s_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table plus random scoreboard run for pipe_skid_reg.
module tb_pipe_skid_reg;

  localparam int unsigned      W  = 16;
  localparam logic [W-1:0]     RV = 16'h5A5A;

  logic clk = 1'b0;
  logic rst, flush;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.WIDTH(W)) bus ();

  pipe_skid_reg #(
    .WIDTH   (W),
    .RST_VAL (RV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic         rst;
    logic         flush;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         ev;
    logic [W-1:0] ed;
    logic         eir;
    logic [1:0]   eocc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic f, input logic iv, input logic [W-1:0] d,
                     input logic ordy, input logic ev, input logic [W-1:0] ed,
                     input logic eir, input logic [1:0] eocc);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.eir = eir; v.eocc = eocc;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference queue for the random run; depth limit 2 mirrors the storage, not the FSM.
  logic [W-1:0] model[$];

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    //  rst flush iv data      ordy | ov  od        ir  occ
    add(1, 0, 1, 16'hDEAD, 0,   0, RV,       1, 0);  // reset
    add(0, 0, 1, 16'h0001, 1,   1, 16'h0001, 1, 1);  // streaming
    add(0, 0, 1, 16'h0002, 1,   1, 16'h0002, 1, 1);
    add(0, 0, 1, 16'h0003, 1,   1, 16'h0003, 1, 1);
    add(0, 0, 0, 16'h0000, 1,   0, 16'h0003, 1, 0);  // drain, M keeps value
    add(0, 0, 0, 16'h0000, 0,   0, 16'h0003, 1, 0);  // idle
    add(0, 0, 1, 16'h000A, 0,   1, 16'h000A, 1, 1);  // stall
    add(0, 0, 1, 16'h000B, 0,   1, 16'h000A, 0, 2);
    add(0, 0, 1, 16'h000C, 0,   1, 16'h000A, 0, 2);  // C held upstream
    add(0, 0, 1, 16'h000C, 1,   1, 16'h000B, 1, 1);
    add(0, 0, 1, 16'h000C, 1,   1, 16'h000C, 1, 1);
    add(0, 0, 0, 16'h0000, 1,   0, 16'h000C, 1, 0);
    add(0, 0, 1, 16'h0010, 0,   1, 16'h0010, 1, 1);  // flush from TWO
    add(0, 0, 1, 16'h0011, 0,   1, 16'h0010, 0, 2);
    add(0, 1, 1, 16'h0012, 0,   0, RV,       1, 0);
    add(0, 0, 0, 16'h0000, 1,   0, RV,       1, 0);
    add(0, 0, 1, 16'h0005, 0,   1, 16'h0005, 1, 1);  // simultaneous in/out
    add(0, 0, 1, 16'h0006, 1,   1, 16'h0006, 1, 1);
    add(0, 1, 1, 16'h0013, 1,   0, RV,       1, 0);  // flush from ONE with fire
    add(0, 0, 1, 16'h0007, 0,   1, 16'h0007, 1, 1);  // reset mid-operation
    add(0, 0, 1, 16'h0008, 0,   1, 16'h0007, 0, 2);
    add(1, 0, 1, 16'h0009, 1,   0, RV,       1, 0);
    add(0, 0, 1, 16'h0021, 0,   1, 16'h0021, 1, 1);
    add(1, 1, 1, 16'h0022, 1,   0, RV,       1, 0);  // rst with flush
    add(0, 0, 1, 16'h0031, 0,   1, 16'h0031, 1, 1);  // TWO drained by out_ready
    add(0, 0, 1, 16'h0032, 0,   1, 16'h0031, 0, 2);
    add(0, 0, 1, 16'h0033, 1,   1, 16'h0032, 1, 1);
    add(0, 0, 0, 16'h0000, 1,   0, 16'h0032, 1, 0);

    @(posedge clk); #1;
    foreach (vq[i]) begin
      rst = vq[i].rst; flush = vq[i].flush;
      bus.in_valid = vq[i].iv; bus.in_data = vq[i].d; bus.out_ready = vq[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vq[i].ev));
      chk($sformatf("v%0d out_data",  i), 32'(bus.out_data),  32'(vq[i].ed));
      chk($sformatf("v%0d in_ready",  i), 32'(bus.in_ready),  32'(vq[i].eir));
      chk($sformatf("v%0d occupancy", i), 32'(bus.occupancy), 32'(vq[i].eocc));
    end

    // Random traffic; the DUT is empty after the last vector.
    rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    model.delete();
    for (int c = 0; c < 10000; c++) begin
      logic iv, ordy, fl, ifire, ofire;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 63) == 0);
      flush = fl; bus.in_valid = iv; bus.out_ready = ordy;
      bus.in_data = W'($urandom);
      @(negedge clk);
      if ((bus.in_ready !== (model.size() < 2)) || (bus.out_valid !== (model.size() > 0)) ||
          (bus.occupancy !== 2'(model.size()))) begin
        bad++;
        $display("FAIL rnd c%0d ctrl: got ir=%0b ov=%0b occ=%0d expected occ=%0d",
                 c, bus.in_ready, bus.out_valid, bus.occupancy, model.size());
      end
      total++;
      if (model.size() > 0) chk($sformatf("rnd c%0d out_data", c), 32'(bus.out_data),
                                32'(model[0]));
      @(posedge clk);
      ifire = iv && (model.size() < 2);
      ofire = ordy && (model.size() > 0);
      if (fl) begin
        model.delete();
      end else begin
        if (ofire) void'(model.pop_front());
        if (ifire) model.push_back(bus.in_data);
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register with valid/ready handshake, a one-entry skid buffer and synchronous flush. It replaces the plain always-load inter-stage data register between CPU pipeline stages, for example PC/IR to execute. Downstream stalls back-pressure upstream without a combinational path from `out_ready` to `in_ready`. A flush discards in-flight data on branch or exception redirects.

## Interface
- `WIDTH`, default 32: payload width in bits.
- `RST_VAL`, default 0: value loaded into both data registers on reset and on flush.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous discard of all stored entries.
- `in_valid`  in  1  upstream has data.
- `in_data`  in  WIDTH  upstream payload.
- `in_ready`  out  1  stage can accept; driven only by flops.
- `out_valid`  out  1  `out_data` holds a live entry.
- `out_data`  out  WIDTH  head entry (main register).
- `out_ready`  in  1  downstream accepts.
- `occupancy`  out  2  number of stored entries, 0..2.

## Operation
- Definitions: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Storage: main register M (drives `out_data`) and skid register S.
- States:
  - EMPTY: 0 entries.
  - ONE: M live.
  - TWO: M and S live.
- Derived outputs:
  - `out_valid = (state != EMPTY)`.
  - `in_ready = (state != TWO)`.
  - `occupancy` = 0, 1 or 2 per state.
- Transitions, when neither `rst` nor `flush` is asserted:
  - EMPTY, `in_fire`: M <= `in_data`, go to ONE.
  - ONE, `in_fire & out_fire`: M <= `in_data`, stay in ONE.
  - ONE, `in_fire & !out_fire`: S <= `in_data`, go to TWO.
  - ONE, `!in_fire & out_fire`: go to EMPTY; M keeps its value.
  - TWO, `out_fire`: M <= S, go to ONE. No `in_fire` is possible in TWO.
  - Any other case: hold state and data.
- Priority: `rst` > `flush` > handshake.
- `flush`: state <= EMPTY, M and S <= `RST_VAL`. Data presented in the flush cycle is dropped, even if `in_valid` and `in_ready` are both high. A downstream `out_fire` in that cycle still counts as consumed by the receiver.
- Ordering: entries leave in arrival order; no entry is duplicated or lost except by flush.
- Data registers load only on the events listed above. No load occurs on idle cycles.

## Timing
- Reset values, on the cycle after `rst` is sampled high:
  - `out_valid` = 0, `out_data` = `RST_VAL`.
  - `in_ready` = 1, `occupancy` = 0.
- Reset mid-operation discards all entries exactly as flush does.
- Latency: 1 cycle from `in_fire` (into EMPTY or ONE-with-drain) to `out_valid`/`out_data` update.
- Throughput: 1 entry per cycle when `out_ready` is held high.
- Back-pressure: when `out_ready` falls with M live and input streaming, the entry arriving that cycle goes to S. `in_ready` deasserts on the next cycle. Recovery: `in_ready` reasserts one cycle after the first `out_fire` in TWO.
- No combinational path from `out_ready` or `in_valid` to any output.

## Structure
- Shared pipeline package holds the state typedef:
  - `PSR_EMPTY = 2'b00`
  - `PSR_ONE = 2'b01`
  - `PSR_TWO = 2'b10`
  - `2'b11` is illegal; the FSM recovers to EMPTY.
- Natural sub-module: `pipe_data_reg`, a WIDTH-bit register with `clk`, `rst`, `clr`, `en`, `d`, `q`. Sync reset/clear to `RST_VAL`, load on `en`. Instantiated twice, for M and S.
- The FSM and mux selection (M from `in_data` or S) live in the top.

## Test plan
- Reset: drive `rst` one cycle with `in_valid=1`, `in_data=0xDEAD` → next cycle `out_valid=0`, `out_data=RST_VAL`, `in_ready=1`, `occupancy=0`.
- Streaming: `out_ready=1`, send 0x1,0x2,0x3 on consecutive cycles → `out_data` 0x1,0x2,0x3 on the three following cycles, `occupancy` stays 1.
- Stall: stream 0xA,0xB,0xC with `out_ready=0` from the cycle 0xA lands → 0xA and 0xB stored, `in_ready=0`, `occupancy=2`, 0xC held upstream. Release `out_ready` → outputs 0xA,0xB,0xC in order, none lost.
- Flush: in TWO with 0x10/0x11 stored, assert `flush` with `in_valid=1`, `in_data=0x12` → next cycle `out_valid=0`, `occupancy=0`, `in_ready=1`, and 0x12 never appears at the output.
- Simultaneous: in ONE (M=0x5), `in_fire`(0x6) and `out_fire` in the same cycle → next cycle `out_data=0x6`, `occupancy=1`. Random valid/ready for 10k cycles → scoreboard shows in-order, lossless transfer.
